pwm_duty_decoder: RTL and testbench

- Receive side of the PWM link. Samples an incoming PWM waveform and measures its period and high time in clk cycles.
- Reports the duty cycle in tenths (0..10), on the same scale used by the PWM generator's duty register.
- Detects loss of signal (constant level) and reports 0 % or 100 % in that case.
- Sits between a PWM input pin or loopback and status/control logic.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_edge_sync.sv | 48 ++++
 rtl/pwm_duty_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants and types for the PWM receive/capture blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Number of duty quanta reported by the decoder (tenths).
    localparam int C_DUTY_STEPS = 10;

    // Width of the reported duty value; holds 0..C_DUTY_STEPS.
    localparam int C_DUTY_W = 4;

    // Measurement FSM: waiting for a reference rise, or measuring rise-to-rise.
    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_edge_sync
//  Description : Two-flop synchroniser for an asynchronous level, followed by
//                an edge register. s_o, rise_det_o and fall_det_o are mutually
//                aligned: on a rise_det_o cycle s_o already reads 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_edge_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic s_o,
    output logic rise_det_o,
    output logic fall_det_o
);

    logic meta_q;
    logic sync_q;
    logic lvl_q;
    logic rise_q;
    logic fall_q;

    // Synchroniser chain plus one level/edge register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pwm_i;
            sync_q <= meta_q;
            lvl_q  <= sync_q;
            rise_q <= sync_q & ~lvl_q;
            fall_q <= ~sync_q & lvl_q;
        end
    end

    assign s_o        = lvl_q;
    assign rise_det_o = rise_q;
    assign fall_det_o = fall_q;

endmodule : pwm_edge_sync
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_decoder
//  Description : Measures period and high time of an incoming PWM waveform,
//                reports duty in DUTY_STEPS quanta and flags loss of signal
//                when the line has been static for TIMEOUT_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int DUTY_STEPS  = C_DUTY_STEPS  // must fit in C_DUTY_W bits
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [C_DUTY_W-1:0] duty_tenths,
    output logic [CNT_W-1:0]    high_cnt,
    output logic [CNT_W-1:0]    period_cnt,
    output logic                meas_valid,
    output logic                no_signal
);

    // Scaled high time needs 4 extra bits to hold high*DUTY_STEPS.
    localparam int               SCL_W     = CNT_W + 4;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // Input synchronisation and edge detection
    // ------------------------------------------------------------------
    logic w_s;
    logic w_rise;
    logic w_fall;

    pwm_edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .pwm_i      (pwm_in),
        .s_o        (w_s),
        .rise_det_o (w_rise),
        .fall_det_o (w_fall)
    );

    // ------------------------------------------------------------------
    // Run counters and FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] per_run_q,  per_run_d;
    logic [CNT_W-1:0] hi_run_q,   hi_run_d;
    logic [CNT_W-1:0] idle_run_q, idle_run_d;
    state_t           state_q,    state_d;
    logic             w_capture;
    logic             w_timeout;

    // Any edge in the same cycle as the timeout threshold suppresses it.
    assign w_timeout = (idle_run_q == C_TIMEOUT) && !w_rise && !w_fall;

    // Saturating run counters; the rise restarts period/high at 1 because the
    // rise cycle itself belongs to the new period and is already high.
    always_comb begin
        per_run_d  = per_run_q;
        hi_run_d   = hi_run_q;
        idle_run_d = idle_run_q;
        if (w_rise) begin
            per_run_d = C_ONE;
            hi_run_d  = C_ONE;
        end else begin
            if (per_run_q != C_CNT_MAX) begin
                per_run_d = per_run_q + C_ONE;
            end
            if (w_s && (hi_run_q != C_CNT_MAX)) begin
                hi_run_d = hi_run_q + C_ONE;
            end
        end
        if (w_rise || w_fall) begin
            idle_run_d = '0;
        end else if (idle_run_q != C_CNT_MAX) begin
            idle_run_d = idle_run_q + C_ONE;
        end
    end

    // Next state and capture strobe; the first rise only arms measurement.
    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        case (state_q)
            ACQUIRE: begin
                if (w_rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                end
            end
            default: state_d = ACQUIRE;
        endcase
        if (w_timeout) begin
            state_d = ACQUIRE;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACQUIRE;
            per_run_q  <= '0;
            hi_run_q   <= '0;
            idle_run_q <= '0;
        end else begin
            state_q    <= state_d;
            per_run_q  <= per_run_d;
            hi_run_q   <= hi_run_d;
            idle_run_q <= idle_run_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: scaled high time and period multiples
    // ------------------------------------------------------------------
    logic [SCL_W-1:0] w_scaled;
    logic [SCL_W-1:0] w_mult      [DUTY_STEPS];
    logic [SCL_W-1:0] st1_mult_q  [DUTY_STEPS];
    logic [SCL_W-1:0] st1_scaled_q;
    logic [CNT_W-1:0] st1_hi_q;
    logic [CNT_W-1:0] st1_per_q;
    logic             st1_valid_q;

    generate
        if (DUTY_STEPS == 10) begin : g_scale_shift
            assign w_scaled = (SCL_W'(hi_run_q) << 3) + (SCL_W'(hi_run_q) << 1);
        end else begin : g_scale_mul
            assign w_scaled = SCL_W'(hi_run_q) * SCL_W'(DUTY_STEPS);
        end
    endgenerate

    generate
        for (genvar k = 0; k < DUTY_STEPS; k++) begin : g_mult
            assign w_mult[k] = SCL_W'(per_run_q) * SCL_W'(k + 1);
        end
    endgenerate

    // Capture counters (pre-restart values) together with the stage-1 products.
    always_ff @(posedge clk) begin
        if (rst) begin
            st1_valid_q  <= 1'b0;
            st1_hi_q     <= '0;
            st1_per_q    <= '0;
            st1_scaled_q <= '0;
            for (int k = 0; k < DUTY_STEPS; k++) begin
                st1_mult_q[k] <= '0;
            end
        end else begin
            st1_valid_q <= w_capture;
            if (w_capture) begin
                st1_hi_q     <= hi_run_q;
                st1_per_q    <= per_run_q;
                st1_scaled_q <= w_scaled;
                for (int k = 0; k < DUTY_STEPS; k++) begin
                    st1_mult_q[k] <= w_mult[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: quantise and update the outputs
    // ------------------------------------------------------------------
    logic [C_DUTY_W-1:0] w_duty;
    logic [C_DUTY_W-1:0] duty_q;
    logic [CNT_W-1:0]    high_q;
    logic [CNT_W-1:0]    period_q;
    logic                valid_q;
    logic                nosig_q;
    logic                to_pend_q;

    // Largest k with k*period <= scaled; multiples ascend so the last hit wins.
    always_comb begin
        w_duty = '0;
        for (int k = 1; k <= DUTY_STEPS; k++) begin
            if (st1_mult_q[k-1] <= st1_scaled_q) begin
                w_duty = C_DUTY_W'(k);
            end
        end
    end

    // Output registers; a pipeline result takes priority and defers a
    // coincident timeout by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q    <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            nosig_q   <= 1'b1;
            to_pend_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (st1_valid_q) begin
                duty_q    <= w_duty;
                high_q    <= st1_hi_q;
                period_q  <= st1_per_q;
                valid_q   <= 1'b1;
                nosig_q   <= 1'b0;
                to_pend_q <= w_timeout;
            end else if (w_timeout || to_pend_q) begin
                duty_q    <= w_s ? C_DUTY_W'(DUTY_STEPS) : '0;
                high_q    <= '0;
                period_q  <= '0;
                valid_q   <= 1'b1;
                nosig_q   <= 1'b1;
                to_pend_q <= 1'b0;
            end
        end
    end

    assign duty_tenths = duty_q;
    assign high_cnt    = high_q;
    assign period_cnt  = period_q;
    assign meas_valid  = valid_q;
    assign no_signal   = nosig_q;

endmodule : pwm_duty_decoder
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_decoder
//  Description : Self-checking bench for pwm_duty_decoder. A behavioural model
//                works on the per-cycle history of sampled input levels and
//                predicts every meas_valid event (time and payload).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_decoder;

    localparam int T = 200;   // timeout used for this bench

    typedef struct packed {
        int          t;
        logic [3:0]  d;
        logic [15:0] h;
        logic [15:0] p;
        logic        ns;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [3:0]  duty_tenths;
    logic [15:0] high_cnt;
    logic [15:0] period_cnt;
    logic        meas_valid;
    logic        no_signal;

    int total = 0;
    int bad   = 0;
    int cyc   = -1;

    bit  hist[$];
    ev_t exp_q[$];
    ev_t obs_q[$];
    int  m_prev;
    int  m_last_rise;
    int  m_last_edge;

    pwm_duty_decoder #(
        .CNT_W       (16),
        .TIMEOUT_CYC (T),
        .DUTY_STEPS  (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .duty_tenths (duty_tenths),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .meas_valid  (meas_valid),
        .no_signal   (no_signal)
    );

    always #5 clk = ~clk;

    // Reference model: consumes the level seen at sample edge c.
    task automatic model_sample(input int c, input logic lvl, input logic r);
        ev_t e;
        int  hi;
        if (r) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].t >= c) exp_q.pop_back();
            hist.push_back(1'b0);
            m_prev      = 0;
            m_last_edge = c - 3;
            m_last_rise = -1;
        end else begin
            hist.push_back(lvl);
            if (int'(lvl) != m_prev) begin
                if (lvl && m_last_rise >= 0) begin
                    hi = 0;
                    for (int i = m_last_rise; i < c; i++) hi += int'(hist[i]);
                    e.t  = c + 4;
                    e.d  = 4'((10 * hi) / (c - m_last_rise));
                    e.h  = 16'(hi);
                    e.p  = 16'(c - m_last_rise);
                    e.ns = 1'b0;
                    exp_q.push_back(e);
                end
                if (lvl) m_last_rise = c;
                m_last_edge = c;
            end else if (c == m_last_edge + T + 1) begin
                e.t  = c + 3;
                e.d  = lvl ? 4'd10 : 4'd0;
                e.h  = '0;
                e.p  = '0;
                e.ns = 1'b1;
                exp_q.push_back(e);
                m_last_rise = -1;
            end
            m_prev = int'(lvl);
        end
    endtask

    // Advance one clock with the given input level and record any output event.
    task automatic step(input logic lvl);
        ev_t o;
        pwm_in = lvl;
        @(posedge clk);
        cyc++;
        model_sample(cyc, lvl, rst);
        #1;
        if (meas_valid === 1'b1) begin
            o.t  = cyc;
            o.d  = duty_tenths;
            o.h  = high_cnt;
            o.p  = period_cnt;
            o.ns = no_signal;
            obs_q.push_back(o);
        end
    endtask

    task automatic drive_pwm(input int per, input int hi, input int n);
        for (int j = 0; j < n; j++)
            for (int i = 0; i < per; i++) step(i < hi);
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hold(1'b0, 3);
        rst = 1'b0;
        total += 5;
        if (duty_tenths !== 4'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", duty_tenths); end
        if (high_cnt !== 16'd0) begin bad++; $display("FAIL reset_high: got %0d want 0", high_cnt); end
        if (period_cnt !== 16'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_cnt); end
        if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
        if (no_signal !== 1'b1) begin bad++; $display("FAIL reset_nosig: got %b want 1", no_signal); end
        hold(1'b0, 5);
        total++;
        if (no_signal !== 1'b1) begin bad++; $display("FAIL reset_nosig_hold: got %b want 1", no_signal); end
    endtask

    task automatic test_basic;
        ev_t e, o;
        int  t0;
        t0 = cyc + 1;
        drive_pwm(10, 5, 5);
        hold(1'b0, 6);
        total += 2;
        if (obs_q.size() !== 4) begin bad++; $display("FAIL basic_count: got %0d want 4", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q[0];
            if (o.t !== t0 + 14 || o.d !== 4'd5 || o.h !== 16'd5 || o.p !== 16'd10 || o.ns !== 1'b0) begin
                bad++;
                $display("FAIL basic_first: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=5 h=5 p=10 ns=0",
                         o.t, o.d, o.h, o.p, o.ns, t0 + 14);
            end
        end else begin
            bad++; $display("FAIL basic_first: got none want t=%0d", t0 + 14);
        end
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL basic_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL basic_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL basic_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_sweep;
        ev_t e, o;
        for (int h = 1; h <= 9; h++) drive_pwm(10, h, 3);
        hold(1'b0, T + 20);
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL sweep_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL sweep_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL sweep_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
        total++;
        if (no_signal !== 1'b1 || duty_tenths !== 4'd0) begin
            bad++; $display("FAIL sweep_timeout_low: got ns=%0b d=%0d want ns=1 d=0", no_signal, duty_tenths);
        end
    endtask

    task automatic test_ratio;
        ev_t e, o;
        drive_pwm(7, 3, 4);
        hold(1'b0, 6);
        total++;
        if (obs_q.size() > 0) begin
            o = obs_q[obs_q.size()-1];
            if (o.d !== 4'd4 || o.h !== 16'd3 || o.p !== 16'd7 || o.ns !== 1'b0) begin
                bad++; $display("FAIL ratio_last: got d=%0d h=%0d p=%0d ns=%0b want d=4 h=3 p=7 ns=0", o.d, o.h, o.p, o.ns);
            end
        end else begin
            bad++; $display("FAIL ratio_last: got none want d=4");
        end
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL ratio_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL ratio_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL ratio_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_timeout_high;
        ev_t e, o;
        int  n_to;
        drive_pwm(10, 5, 2);
        hold(1'b1, 2 * T + 60);
        n_to = 0;
        foreach (obs_q[i]) if (obs_q[i].ns === 1'b1) n_to++;
        total++;
        if (n_to !== 1) begin bad++; $display("FAIL to_high_count: got %0d timeout pulses want 1", n_to); end
        total++;
        if (duty_tenths !== 4'd10 || high_cnt !== 16'd0 || period_cnt !== 16'd0 || no_signal !== 1'b1) begin
            bad++; $display("FAIL to_high_state: got d=%0d h=%0d p=%0d ns=%0b want d=10 h=0 p=0 ns=1", duty_tenths, high_cnt, period_cnt, no_signal);
        end
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL to_high_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL to_high_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL to_high_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_restart;
        ev_t e, o;
        int  t0;
        hold(1'b0, T + 20);
        t0 = cyc + 1;
        drive_pwm(10, 4, 3);
        hold(1'b0, 6);
        total++;
        begin
            int first_t;
            first_t = -1;
            foreach (obs_q[i]) if (first_t < 0 && obs_q[i].ns === 1'b0) first_t = obs_q[i].t;
            if (first_t !== t0 + 14) begin bad++; $display("FAIL restart_first: got t=%0d want t=%0d", first_t, t0 + 14); end
        end
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL restart_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL restart_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL restart_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid;
        ev_t e, o;
        drive_pwm(10, 5, 3);
        hold(1'b1, 2);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        total++;
        if (duty_tenths !== 4'd0 || high_cnt !== 16'd0 || period_cnt !== 16'd0 || meas_valid !== 1'b0 || no_signal !== 1'b1) begin
            bad++; $display("FAIL midrst_state: got d=%0d h=%0d p=%0d v=%0b ns=%0b want d=0 h=0 p=0 v=0 ns=1",
                            duty_tenths, high_cnt, period_cnt, meas_valid, no_signal);
        end
        hold(1'b1, 2);
        hold(1'b0, 5);
        drive_pwm(10, 5, 3);
        hold(1'b0, 6);
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL midrst_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL midrst_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL midrst_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_random;
        ev_t e, o;
        int  per, hi;
        for (int it = 0; it < 16; it++) begin
            per = int'($urandom_range(2, 40));
            hi  = int'($urandom_range(1, per - 1));
            drive_pwm(per, hi, int'($urandom_range(2, 4)));
        end
        hold(1'b0, T + 10);
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL random_missing: got none want t=%0d d=%0d", e.t, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL random_evt: got t=%0d d=%0d h=%0d p=%0d ns=%0b want t=%0d d=%0d h=%0d p=%0d ns=%0b", o.t, o.d, o.h, o.p, o.ns, e.t, e.d, e.h, e.p, e.ns); end
            end
        end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL random_extra: got %0d spurious want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_sweep();
        test_ratio();
        test_timeout_high();
        test_restart();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_duty_decoder
`default_nettype wire
